// File: rtl/asic_mem_responder.sv
// ---------------------------------------------------------------------------
// asic_mem_responder
//
// Memory-side responder for a 40-bit address / 64-bit data memory port.
// Requests arrive over a val/rdy handshake and are serviced from a local
// array of 64-bit words. Each accepted request produces exactly one response,
// in request order, LAT cycles after acceptance when nothing is queued ahead
// of it. The number of outstanding requests (accepted, response not yet
// taken) is capped at DEPTH, so the response FIFO can never overflow.
//
// Parameters
//   NWORDS  number of 64-bit words in the array (power of 2, >= 2)
//   LAT     accept-to-response latency in cycles when unstalled (>= 1)
//   DEPTH   maximum outstanding requests / response FIFO entries (>= 1)
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   reset          in   synchronous active-high reset
//   mem_req_val    in   request valid
//   mem_req_rdy    out  responder can accept a request this cycle
//   mem_req_type   in   0 = read, 1 = write
//   mem_req_addr   in   40-bit byte address, word index = addr[3 +: log2(NWORDS)]
//   mem_req_data   in   64-bit write data (ignored for reads)
//   mem_resp_val   out  response valid
//   mem_resp_rdy   in   consumer takes the response this cycle
//   mem_resp_type  out  echo of the request type
//   mem_resp_addr  out  echo of the full request address
//   mem_resp_data  out  read: word read, write: word written
// ---------------------------------------------------------------------------
module asic_mem_responder #(
  parameter int NWORDS = 256,
  parameter int LAT    = 2,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req_val,
  output logic        mem_req_rdy,
  input  logic        mem_req_type,
  input  logic [39:0] mem_req_addr,
  input  logic [63:0] mem_req_data,
  output logic        mem_resp_val,
  input  logic        mem_resp_rdy,
  output logic        mem_resp_type,
  output logic [39:0] mem_resp_addr,
  output logic [63:0] mem_resp_data
);

  localparam int AW = $clog2(NWORDS);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // FIFO pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [63:0]   mem_q [NWORDS];
  logic [63:0]   mem_d [NWORDS];

  logic          req_fire;
  logic          resp_fire;
  logic [AW-1:0] req_idx;
  logic [63:0]   req_result;

  logic          enq_val;
  logic          enq_type;
  logic [39:0]   enq_addr;
  logic [63:0]   enq_data;

  logic          fifo_type_q [DEPTH];
  logic          fifo_type_d [DEPTH];
  logic [39:0]   fifo_addr_q [DEPTH];
  logic [39:0]   fifo_addr_d [DEPTH];
  logic [63:0]   fifo_data_q [DEPTH];
  logic [63:0]   fifo_data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic          fifo_full;

  // Handshakes. Request ready looks only at the registered outstanding
  // count so there is no combinational path from mem_resp_rdy.
  always_comb begin
    mem_req_rdy  = !reset && (outstanding_q < CW'(DEPTH));
    mem_resp_val = !reset && (fifo_cnt_q != '0);
    req_fire     = mem_req_val && mem_req_rdy;
    resp_fire    = mem_resp_val && mem_resp_rdy;
    req_idx      = mem_req_addr[3 +: AW];
    // A read samples the array before this cycle's edge, so it sees every
    // write accepted in an earlier cycle. A write returns its own data.
    req_result   = mem_req_type ? mem_req_data : mem_q[req_idx];
  end

  // Outstanding count: requests accepted whose response has not been taken.
  always_comb begin
    outstanding_d = outstanding_q;
    if (req_fire && !resp_fire) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!req_fire && resp_fire) begin
      outstanding_d = outstanding_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  // Word array. A write lands on the edge that ends its accept cycle.
  always_comb begin
    mem_d = mem_q;
    if (req_fire && mem_req_type) begin
      mem_d[req_idx] = mem_req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NWORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Delay line. The FIFO write itself is the final stage of latency, so only
  // LAT-1 register stages sit in front of it; with LAT = 1 the accepted
  // request is enqueued directly on its accept edge.
  if (LAT == 1) begin : g_nopipe
    assign enq_val  = req_fire;
    assign enq_type = mem_req_type;
    assign enq_addr = mem_req_addr;
    assign enq_data = req_result;
  end else begin : g_pipe
    logic        pipe_val_q  [LAT-1];
    logic        pipe_val_d  [LAT-1];
    logic        pipe_type_q [LAT-1];
    logic        pipe_type_d [LAT-1];
    logic [39:0] pipe_addr_q [LAT-1];
    logic [39:0] pipe_addr_d [LAT-1];
    logic [63:0] pipe_data_q [LAT-1];
    logic [63:0] pipe_data_d [LAT-1];

    // Shift every cycle; the line never stalls because the FIFO is sized
    // to absorb everything that can be outstanding.
    always_comb begin
      pipe_val_d[0]  = req_fire;
      pipe_type_d[0] = mem_req_type;
      pipe_addr_d[0] = mem_req_addr;
      pipe_data_d[0] = req_result;
      for (int k = 1; k < LAT - 1; k++) begin
        pipe_val_d[k]  = pipe_val_q[k-1];
        pipe_type_d[k] = pipe_type_q[k-1];
        pipe_addr_d[k] = pipe_addr_q[k-1];
        pipe_data_d[k] = pipe_data_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < LAT - 1; k++) begin
          pipe_val_q[k]  <= 1'b0;
          pipe_type_q[k] <= 1'b0;
          pipe_addr_q[k] <= '0;
          pipe_data_q[k] <= '0;
        end
      end else begin
        pipe_val_q  <= pipe_val_d;
        pipe_type_q <= pipe_type_d;
        pipe_addr_q <= pipe_addr_d;
        pipe_data_q <= pipe_data_d;
      end
    end

    assign enq_val  = pipe_val_q[LAT-2];
    assign enq_type = pipe_type_q[LAT-2];
    assign enq_addr = pipe_addr_q[LAT-2];
    assign enq_data = pipe_data_q[LAT-2];
  end

  // Response FIFO. An occupancy count separates full from empty, and
  // simultaneous enqueue/dequeue leaves the count unchanged.
  always_comb begin
    fifo_type_d = fifo_type_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    fifo_full   = (fifo_cnt_q == CW'(DEPTH));
    if (enq_val) begin
      fifo_type_d[wr_ptr_q] = enq_type;
      fifo_addr_d[wr_ptr_q] = enq_addr;
      fifo_data_d[wr_ptr_q] = enq_data;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (resp_fire) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (enq_val && !resp_fire) begin
      fifo_cnt_d = fifo_cnt_q + CW'(1);
    end else if (!enq_val && resp_fire) begin
      fifo_cnt_d = fifo_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_type_q[i] <= 1'b0;
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      fifo_type_q <= fifo_type_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // The response port always shows the FIFO head, so it holds steady
  // while the consumer stalls.
  always_comb begin
    mem_resp_type = fifo_type_q[rd_ptr_q];
    mem_resp_addr = fifo_addr_q[rd_ptr_q];
    mem_resp_data = fifo_data_q[rd_ptr_q];
  end

  // The credit limit makes an enqueue into a full FIFO impossible unless
  // the head leaves on the same edge.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(enq_val && fifo_full && !resp_fire));

endmodule
